// File: rtl/rails_multi.sv
// Multi-channel rail-yard checker: CH departure orders are tested against one LIFO siding.
// Optional status outputs (busy, fail_idx) are enabled by defining RAILS_STATUS_EN.
module rails_multi #(
  parameter int DW    = 4,
  parameter int MAX_N = 10,
  parameter int CH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    number,
  input  logic [CH*DW-1:0] data,
  output logic             valid,
  output logic [CH-1:0]    result
`ifdef RAILS_STATUS_EN
  ,
  output logic             busy,
  output logic [CH*DW-1:0] fail_idx
`endif
);

  // Counters must hold n+1 (next train to push), so one bit wider than an id.
  localparam int CW = DW + 1;
  localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  typedef enum logic [1:0] {S_NUM, S_LOAD, S_CHECK, S_OUT} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     n_q, n_d;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     load_q, load_d;
  logic [DW-1:0]     order_q [CH][MAX_N];
  logic [DW-1:0]     order_d [CH][MAX_N];
  logic [DW-1:0]     stack_q [CH][MAX_N];
  logic [DW-1:0]     stack_d [CH][MAX_N];
  logic [CW-1:0]     sp_q   [CH];
  logic [CW-1:0]     sp_d   [CH];
  logic [CW-1:0]     idx_q  [CH];
  logic [CW-1:0]     idx_d  [CH];
  logic [CW-1:0]     next_q [CH];
  logic [CW-1:0]     next_d [CH];
  logic [CH-1:0]     fail_q, fail_d;
  logic              valid_q, valid_d;
  logic [CH-1:0]     result_q, result_d;
  logic [CH-1:0]     done;
  logic              all_done;
  logic              ovf_now;
`ifdef RAILS_STATUS_EN
  logic              busy_q, busy_d;
  logic [CH*DW-1:0]  fail_idx_q, fail_idx_d;
`endif

  assign ovf_now = {1'b0, number} > CW'(MAX_N);

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    ovf_d    = ovf_q;
    load_d   = load_q;
    order_d  = order_q;
    stack_d  = stack_q;
    sp_d     = sp_q;
    idx_d    = idx_q;
    next_d   = next_q;
    fail_d   = fail_q;
    valid_d  = 1'b0;
    result_d = result_q;
`ifdef RAILS_STATUS_EN
    fail_idx_d = fail_idx_q;
`endif

    for (int c = 0; c < CH; c++) begin
      done[c] = ovf_q | fail_q[c] | (idx_q[c] == CW'(n_q));
    end
    all_done = &done;

    case (state_q)
      S_NUM: begin
        n_d    = number;
        ovf_d  = ovf_now;
        load_d = '0;
        fail_d = '0;
        for (int c = 0; c < CH; c++) begin
          sp_d[c]   = '0;
          idx_d[c]  = '0;
          next_d[c] = CW'(1);
        end
        state_d = (number == '0 || ovf_now) ? S_CHECK : S_LOAD;
      end

      S_LOAD: begin
        for (int c = 0; c < CH; c++) begin
          order_d[c][AW'(load_q)] = data[c*DW +: DW];
        end
        load_d = load_q + CW'(1);
        if (load_d == CW'(n_q)) state_d = S_CHECK;
      end

      S_CHECK: begin
        if (all_done) begin
          state_d = S_OUT;
          valid_d = 1'b1;
          for (int c = 0; c < CH; c++) begin
            result_d[c] = ~ovf_q & (idx_q[c] == CW'(n_q));
`ifdef RAILS_STATUS_EN
            // A failed channel freezes idx, so it still names the failing position here.
            fail_idx_d[c*DW +: DW] = fail_q[c] ? DW'(idx_q[c]) : '0;
`endif
          end
        end else begin
          for (int c = 0; c < CH; c++) begin
            if (!done[c]) begin
              if (sp_q[c] != '0 &&
                  stack_q[c][AW'(sp_q[c] - CW'(1))] == order_q[c][AW'(idx_q[c])]) begin
                sp_d[c]  = sp_q[c] - CW'(1);
                idx_d[c] = idx_q[c] + CW'(1);
              end else if (next_q[c] <= CW'(n_q)) begin
                stack_d[c][AW'(sp_q[c])] = DW'(next_q[c]);
                sp_d[c]   = sp_q[c] + CW'(1);
                next_d[c] = next_q[c] + CW'(1);
              end else begin
                fail_d[c] = 1'b1;
              end
            end
          end
        end
      end

      S_OUT:   state_d = S_NUM;
      default: state_d = S_NUM;
    endcase

`ifdef RAILS_STATUS_EN
    busy_d = (state_d == S_LOAD) || (state_d == S_CHECK);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_NUM;
      n_q      <= '0;
      ovf_q    <= 1'b0;
      load_q   <= '0;
      sp_q     <= '{default: '0};
      idx_q    <= '{default: '0};
      next_q   <= '{default: '0};
      fail_q   <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
`ifdef RAILS_STATUS_EN
      busy_q     <= 1'b0;
      fail_idx_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      ovf_q    <= ovf_d;
      load_q   <= load_d;
      sp_q     <= sp_d;
      idx_q    <= idx_d;
      next_q   <= next_d;
      fail_q   <= fail_d;
      valid_q  <= valid_d;
      result_q <= result_d;
`ifdef RAILS_STATUS_EN
      busy_q     <= busy_d;
      fail_idx_q <= fail_idx_d;
`endif
    end
    // NOTE: order/stack storage is left out of reset; sp/idx/load gate every read of it.
    order_q <= order_d;
    stack_q <= stack_d;
  end

  assign valid  = valid_q;
  assign result = result_q;
`ifdef RAILS_STATUS_EN
  assign busy     = busy_q;
  assign fail_idx = fail_idx_q;
`endif

endmodule

// File: tb/tb_rails_multi.sv
// Self-checking bench for rails_multi: directed frames, reset aborts and random frames
// checked against a queue-based stack-permutation model.
module tb_rails_multi;

  localparam int DW     = 4;
  localparam int MAX_N  = 10;
  localparam int CH     = 2;
  localparam int DATA_W = CH * DW;

  typedef int ord_t [CH][MAX_N];

  logic              clk = 1'b0;
  logic              reset;
  logic [DW-1:0]     number;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic [CH-1:0]     result;
`ifdef RAILS_STATUS_EN
  logic              busy;
  logic [DATA_W-1:0] fail_idx;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [CH-1:0] last_res;
  bit          prev_out;

  rails_multi #(.DW(DW), .MAX_N(MAX_N), .CH(CH)) dut (
    .clk    (clk),
    .reset  (reset),
    .number (number),
    .data   (data),
    .valid  (valid),
    .result (result)
`ifdef RAILS_STATUS_EN
    ,
    .busy     (busy),
    .fail_idx (fail_idx)
`endif
  );

  always #5 clk = ~clk;

  // Greedy stack-permutation reference: push until the wanted train is on top, then pop.
  function automatic void model(input int n, input int ord[MAX_N],
                                output bit pass, output int fidx, output int acts);
    int stk[$];
    int nxt = 1;
    pass = 1'b1;
    fidx = 0;
    acts = 0;
    for (int i = 0; i < n; i++) begin
      while ((stk.size() == 0 || stk[$] != ord[i]) && nxt <= n) begin
        stk.push_back(nxt);
        nxt++;
        acts++;
      end
      acts++;
      if (stk.size() != 0 && stk[$] == ord[i]) begin
        void'(stk.pop_back());
      end else begin
        pass = 1'b0;
        fidx = i;
        return;
      end
    end
  endfunction

  function automatic void gen_stackable(input int n, output int o[MAX_N]);
    int stk[$];
    int nxt = 1;
    int k = 0;
    o = '{default: 0};
    while (k < n) begin
      if (stk.size() != 0 && (nxt > n || $urandom_range(1, 0) == 1)) begin
        o[k] = stk.pop_back();
        k++;
      end else begin
        stk.push_back(nxt);
        nxt++;
      end
    end
  endfunction

  function automatic void gen_perm(input int n, output int o[MAX_N]);
    int j, t;
    o = '{default: 0};
    for (int i = 0; i < n; i++) o[i] = i + 1;
    for (int i = n - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = o[i]; o[i] = o[j]; o[j] = t;
    end
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b result=%b, required valid=0 result=00", valid, result);
    end
    reset    = 1'b0;
    last_res = '0;
    prev_out = 1'b0;
  endtask

  // Runs one complete frame and compares result, latency, output hold and status.
  task automatic do_frame(input int n, input ord_t ord, input string tag);
    logic [CH-1:0] exp_res;
    bit            pass;
    bit            ovf;
    bit            got;
    bit            hold_ok;
    bit            busy_ok;
    int            fidx [CH];
    int            acts, acts_max, exp_lat, e;

    ovf      = (n > MAX_N);
    acts_max = 0;
    for (int c = 0; c < CH; c++) begin
      model(n, ord[c], pass, fidx[c], acts);
      exp_res[c] = pass & ~ovf;
      if (pass) fidx[c] = 0;
      if (acts > acts_max) acts_max = acts;
    end
    exp_lat = n + acts_max + 1;

    @(negedge clk);
    if (prev_out) begin
      checks++;
      if (valid !== 1'b0 || result !== last_res) begin
        errors++;
        $display("FAIL %s strobe_one_cycle: valid=%b result=%b, required valid=0 result=%b",
                 tag, valid, result, last_res);
      end
    end
    number = DW'(n);
    data   = DATA_W'($urandom);
    @(posedge clk);

    e       = 0;
    got     = 1'b0;
    hold_ok = 1'b1;
    busy_ok = 1'b1;
    while (!got && e < 300) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        got = 1'b1;
      end else begin
        if (result !== last_res) hold_ok = 1'b0;
`ifdef RAILS_STATUS_EN
        if (!ovf && busy !== 1'b1) busy_ok = 1'b0;
`endif
        if (!ovf && e < n) begin
          for (int c = 0; c < CH; c++) data[c*DW +: DW] = DW'(ord[c][e]);
        end else begin
          data = DATA_W'($urandom);
        end
        number = DW'($urandom);
        @(posedge clk);
        e++;
      end
    end

    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s valid_timeout: no valid within %0d cycles", tag, e);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL %s result: got %b, required %b", tag, result, exp_res);
    end
    if (!ovf) begin
      checks++;
      if (e != exp_lat) begin
        errors++;
        $display("FAIL %s latency: valid after %0d cycles, required %0d", tag, e, exp_lat);
      end
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s result_hold: result changed before valid, required %b held", tag, last_res);
    end
`ifdef RAILS_STATUS_EN
    checks++;
    if (!busy_ok || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: busy_ok=%b busy_in_out=%b, required 1 and 0", tag, busy_ok, busy);
    end
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (fail_idx[c*DW +: DW] !== DW'(ovf ? 0 : fidx[c])) begin
        errors++;
        $display("FAIL %s fail_idx ch%0d: got %0d, required %0d", tag, c,
                 fail_idx[c*DW +: DW], ovf ? 0 : fidx[c]);
      end
    end
`else
    if (busy_ok != 1'b1) errors++;
`endif
    last_res = exp_res;
    prev_out = 1'b1;
  endtask

  task automatic test_directed();
    ord_t o;
    o = '{'{5,4,3,2,1,0,0,0,0,0}, '{5,4,1,2,3,0,0,0,0,0}};
    do_frame(5, o, "t1_n5");
    o = '{'{1,2,3,4,0,0,0,0,0,0}, '{3,2,4,1,0,0,0,0,0,0}};
    do_frame(4, o, "t2_n4");
    o = '{'{3,1,2,0,0,0,0,0,0,0}, '{2,1,3,0,0,0,0,0,0,0}};
    do_frame(3, o, "t2_n3");
    o = '{default: '{default: 0}};
    do_frame(0, o, "t3_n0");
    o = '{'{1,2,3,4,5,6,7,8,9,10}, '{1,2,3,4,5,6,7,8,9,10}};
    do_frame(MAX_N + 1, o, "t4_ovf");
    o = '{'{10,9,8,7,6,5,4,3,2,1}, '{10,9,8,7,6,5,4,3,2,1}};
    do_frame(MAX_N, o, "t4_full");
    o = '{'{1,1,2,0,0,0,0,0,0,0}, '{0,2,3,0,0,0,0,0,0,0}};
    do_frame(3, o, "t5_bad_ids");
  endtask

  // Starts an n=4 frame, then resets it after 'cyc' cycles past the NUM cycle.
  task automatic test_abort(input int cyc, input string tag);
    ord_t o;
    bit   saw_valid = 1'b0;
    o = '{'{2,1,0,0,0,0,0,0,0,0}, '{1,2,0,0,0,0,0,0,0,0}};
    @(negedge clk);
    number = DW'(4);
    @(posedge clk);
    for (int e = 0; e < cyc; e++) begin
      @(negedge clk);
      if (valid !== 1'b0) saw_valid = 1'b1;
      data = (e < 4) ? DATA_W'(e + 1 + ((e + 1) << DW)) : DATA_W'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (saw_valid || valid !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL %s abort: saw_valid=%b valid=%b result=%b, required 0/0/00",
               tag, saw_valid, valid, result);
    end
    last_res = '0;
    prev_out = 1'b0;
    do_frame(2, o, {tag, "_after"});
  endtask

  task automatic test_random(input int frames);
    ord_t o;
    int   n, mode;
    for (int f = 0; f < frames; f++) begin
      n = int'($urandom_range(MAX_N + 2, 0));
      for (int c = 0; c < CH; c++) begin
        mode = int'($urandom_range(2, 0));
        if (mode == 0) gen_stackable(n, o[c]);
        else if (mode == 1) gen_perm(n, o[c]);
        else for (int i = 0; i < MAX_N; i++) o[c][i] = int'($urandom_range(15, 0));
      end
      do_frame(n, o, "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    number   = '0;
    data     = '0;
    last_res = '0;
    prev_out = 1'b0;
    test_reset();
    test_directed();
    test_abort(2, "abort_load");
    test_abort(8, "abort_check");
    test_random(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
